// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared FSM state type, funct3 codes and access checks for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_RMW_READ = 3'd2,
      S_WRITE    = 3'd3,
      S_RESP     = 3'd4
   } lsu_state_e;

   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
      logic legal;
      if (we)
         legal = (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W);
      else
         legal = (funct3 == c_F3_B) || (funct3 == c_F3_H) || (funct3 == c_F3_W) ||
                 (funct3 == c_F3_BU) || (funct3 == c_F3_HU);
      return !legal;
   endfunction

   // funct3[1:0] encodes the access size for every legal code.
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
      return ((funct3[1:0] == 2'b01) && byte_off[0]) ||
             ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_extend
// Description : Lane select with sign/zero extension for loads, and byte or
//               halfword lane merge for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_byte_off,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_byte_off)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
   end

   always_comb begin
      o_load_data = i_word;
      case (i_funct3)
         c_F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
         c_F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
         c_F3_BU: o_load_data = {24'h0, w_byte};
         c_F3_HU: o_load_data = {16'h0, w_half};
         default: o_load_data = i_word;
      endcase
   end

   always_comb begin
      o_merged = i_word;
      case (i_funct3)
         c_F3_B: begin
            case (i_byte_off)
               2'd0:    o_merged[7:0]   = i_wdata[7:0];
               2'd1:    o_merged[15:8]  = i_wdata[7:0];
               2'd2:    o_merged[23:16] = i_wdata[7:0];
               default: o_merged[31:24] = i_wdata[7:0];
            endcase
         end
         c_F3_H: begin
            if (i_byte_off[1])
               o_merged[31:16] = i_wdata[15:0];
            else
               o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32 load/store unit on a word-addressed data memory with
//               read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  r_state;
   lsu_state_e  w_state_nxt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_merged;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        w_accept;
   logic        w_bad;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   lsu_extend u_extend (
      .i_word      (mem_read_data),
      .i_byte_off  (r_addr[1:0]),
      .i_funct3    (r_funct3),
      .i_wdata     (r_wdata),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_bad    = lsu_illegal(req_we, req_funct3) || lsu_misaligned(req_funct3, req_addr[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_err         = 1'b0;
      resp_rdata       = 32'h0;
      mem_address      = {2'b00, r_addr[31:2]};
      mem_write_data   = 32'h0;
      mem_write_enable = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready   = 1'b1;
            mem_address = 32'h0;
            if (req_valid) begin
               if (w_bad)
                  w_state_nxt = S_RESP;
               else if (!req_we)
                  w_state_nxt = S_LOAD;
               else if (req_funct3 == c_F3_W)
                  w_state_nxt = S_WRITE;
               else
                  w_state_nxt = S_RMW_READ;
            end
         end
         S_LOAD:     w_state_nxt = S_RESP;
         S_RMW_READ: w_state_nxt = S_WRITE;
         S_WRITE: begin
            mem_write_enable = r_we;
            mem_write_data   = r_merged;
            w_state_nxt      = S_RESP;
         end
         S_RESP: begin
            resp_valid  = 1'b1;
            resp_err    = r_err;
            resp_rdata  = r_rdata;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_merged starts as the raw store data so SW needs no read phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_merged <= 32'h0;
         r_rdata  <= 32'h0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
         r_merged <= req_wdata;
         r_rdata  <= 32'h0;
         r_err    <= w_bad;
      end else if (r_state == S_LOAD) begin
         r_rdata  <= w_load_data;
      end else if (r_state == S_RMW_READ) begin
         r_merged <= w_merged;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:15];
   int          wr_count = 0;
   int          rsp_count = 0;
   logic [31:0] last_waddr = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_err         (resp_err),
      .resp_rdata       (resp_rdata),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
   );

   assign mem_read_data = mem[mem_address[3:0]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[5] <= 32'h8899AABB;
      end else if (mem_write_enable) begin
         mem[mem_address[3:0]] <= mem_write_data;
      end
   end

   always @(posedge clk) begin
      if (mem_write_enable) begin
         wr_count   <= wr_count + 1;
         last_waddr <= mem_address;
         last_wdata <= mem_write_data;
      end
      if (resp_valid) rsp_count <= rsp_count + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic logic m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int   size;
      logic legal;
      size  = 1 << f3[1:0];
      legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
      return !legal || ((a % size) != 0);
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      logic [63:0] v;
      int          size;
      size = 1 << f3[1:0];
      v = {32'h0, word} >> (8 * a[1:0]);
      if (size == 1) begin
         v = v & 64'hFF;
         if (!f3[2] && v[7]) v = v | 64'hFFFF_FF00;
      end else if (size == 2) begin
         v = v & 64'hFFFF;
         if (!f3[2] && v[15]) v = v | 64'hFFFF_0000;
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_merge(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word, input logic [31:0] wd);
      logic [63:0] mask;
      int          size;
      size = 1 << f3[1:0];
      mask = ((64'd1 << (8 * size)) - 64'd1) << (8 * a[1:0]);
      return (word & ~mask[31:0]) | ((wd << (8 * a[1:0])) & mask[31:0]);
   endfunction

   logic        m_busy = 1'b0;
   int          m_cyc = 0;
   int          m_lat = 0;
   int          m_wcyc = 0;
   logic        m_err = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   logic [31:0] m_waddr = 32'h0;
   logic [31:0] m_wdata = 32'h0;

   // Cycle k after the accept edge is m_cyc == k.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  <= 1'b1;
            m_cyc   <= 1;
            m_err   <= m_bad(req_we, req_funct3, req_addr);
            m_lat   <= m_bad(req_we, req_funct3, req_addr) ? 1 :
                       (!req_we || req_funct3 == 3'd2) ? 2 : 3;
            m_wcyc  <= (m_bad(req_we, req_funct3, req_addr) || !req_we) ? 0 :
                       (req_funct3 == 3'd2) ? 1 : 2;
            m_rdata <= (m_bad(req_we, req_funct3, req_addr) || req_we) ? 32'h0 :
                       m_load(req_funct3, req_addr, mem[req_addr[5:2]]);
            m_waddr <= req_addr >> 2;
            m_wdata <= m_merge(req_funct3, req_addr, mem[req_addr[5:2]], req_wdata);
         end
      end else if (m_cyc == m_lat) begin
         m_busy <= 1'b0;
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      logic exp_rv;
      logic exp_wr;
      exp_rv = m_busy && (m_cyc == m_lat);
      exp_wr = m_busy && (m_wcyc != 0) && (m_cyc == m_wcyc);
      chk("req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rv});
      chk("resp_err", {31'h0, resp_err}, {31'h0, exp_rv && m_err});
      chk("mem_write_enable", {31'h0, mem_write_enable}, {31'h0, exp_wr});
      if (exp_rv) chk("resp_rdata", resp_rdata, m_rdata);
      if (exp_wr) begin
         chk("mem_address", mem_address, m_waddr);
         chk("mem_write_data", mem_write_data, m_wdata);
      end
      if (!m_busy) chk("idle_mem_address", mem_address, 32'h0);
   end

   // ---------------- directed stimulus ----------------
   task automatic access(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
      int n;
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk({name, "_accept_timeout"}, 32'h0, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
      chk({name, "_rdata"}, resp_rdata, exp_rdata);
   endtask

   initial begin
      int w0;
      int r0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
      chk("rst_mem_wdata", mem_write_data, 32'h0);
      rst_n = 1'b1;

      access("lb_16",  1'b0, 3'b000, 32'h16, 32'h0, 2, 1'b0, 32'hFFFFFF99);
      access("lhu_16", 1'b0, 3'b101, 32'h16, 32'h0, 2, 1'b0, 32'h00008899);
      access("lh_14",  1'b0, 3'b001, 32'h14, 32'h0, 2, 1'b0, 32'hFFFFAABB);
      access("lbu_17", 1'b0, 3'b100, 32'h17, 32'h0, 2, 1'b0, 32'h00000088);

      w0 = wr_count;
      access("sb_15",  1'b1, 3'b000, 32'h15, 32'h12, 3, 1'b0, 32'h0);
      chk("sb_15_wcount", wr_count - w0, 1);
      chk("sb_15_waddr", last_waddr, 32'h5);
      chk("sb_15_wdata", last_wdata, 32'h889912BB);
      access("lw_14",  1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'h889912BB);

      access("sh_16",  1'b1, 3'b001, 32'h16, 32'h1234CAFE, 3, 1'b0, 32'h0);
      chk("sh_16_wdata", last_wdata, 32'hCAFE12BB);

      w0 = wr_count;
      access("lw_02",  1'b0, 3'b010, 32'h02, 32'h0, 1, 1'b1, 32'h0);
      access("sh_01",  1'b1, 3'b001, 32'h01, 32'hFFFF, 1, 1'b1, 32'h0);
      access("ld_f3_3", 1'b0, 3'b011, 32'h00, 32'h0, 1, 1'b1, 32'h0);
      access("st_f3_4", 1'b1, 3'b100, 32'h00, 32'h0, 1, 1'b1, 32'h0);
      chk("err_no_write", wr_count - w0, 0);

      // SW with req_valid held through the busy cycles.
      w0 = wr_count;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      chk("sw_c1_we", {31'h0, mem_write_enable}, 32'h1);
      chk("sw_c1_addr", mem_address, 32'h8);
      chk("sw_c1_data", mem_write_data, 32'hDEADBEEF);
      chk("sw_c1_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk("sw_c2_resp", {31'h0, resp_valid}, 32'h1);
      chk("sw_c2_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk("sw_c3_ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("sw_hold_wcount", wr_count - w0, 2);

      // Reset while in the read phase of a byte store.
      w0 = wr_count;
      r0 = rsp_count;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h15; req_wdata = 32'h34;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw_busy", {31'h0, req_ready}, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ready", {31'h0, req_ready}, 32'h1);
      chk("abort_we", {31'h0, mem_write_enable}, 32'h0);
      chk("abort_addr", mem_address, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_wcount", wr_count - w0, 0);
      chk("abort_rcount", rsp_count - r0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
